// File: rtl/pwm_duty_ramper_if.sv
// Request channel for pwm_duty_ramper: target duty and ramp rate over valid/ready.
interface pwm_duty_ramper_if #(
  parameter int N = 4,
  parameter int R = 8
);
  logic [N-1:0] target;
  logic [R-1:0] rate;
  logic         target_valid;
  logic         target_ready;

  modport master (output target, rate, target_valid, input target_ready);
  modport slave  (input target, rate, target_valid, output target_ready);
endinterface

// File: rtl/pwm_duty_ramper.sv
// Soft-start / fade controller: walks pwm duty one LSB per rate_eff PWM periods
// toward a requested target, changing duty only on period boundaries.
module pwm_duty_ramper #(
  parameter int N = 4,
  parameter int R = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          step,
  pwm_duty_ramper_if.slave req,
  output logic [N-1:0]  duty,
  output logic          busy,
  output logic          done,
  output logic          period_start
);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] phase_q, phase_d;
  logic [R-1:0] div_q, div_d;
  logic [R-1:0] rate_q, rate_d;
  logic [N-1:0] tgt_q, tgt_d;
  logic [N-1:0] duty_q, duty_d;
  logic         done_q, done_d;
  logic         ps_q, ps_d;

  logic         boundary;
  logic         accept;
  logic [N-1:0] duty_nxt;

  // Ready is gated by reset so the channel reads not-ready while held in reset.
  assign req.target_ready = rst && ena && (state_q == IDLE);
  assign accept   = req.target_valid && req.target_ready;
  // A boundary is the step that wraps the phase, matching pwm's counter.
  assign boundary = ena && step && (phase_q == {N{1'b1}});
  // Next duty one LSB toward the target; only used while tgt differs from duty.
  assign duty_nxt = (tgt_q > duty_q) ? duty_q + N'(1) : duty_q - N'(1);

  assign duty         = duty_q;
  assign busy         = (state_q == RAMP);
  // Pulses are suppressed while frozen, even if one was registered just before.
  assign done         = done_q && ena;
  assign period_start = ps_q && ena;

  // Next-state logic: phase counting, request latch and ramp stepping.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    rate_d  = rate_q;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
    ps_d    = 1'b0;
    if (ena) begin
      if (step) phase_d = phase_q + N'(1);
      ps_d = boundary;
      case (state_q)
        IDLE: begin
          // A boundary coinciding with the accept is not counted for the new ramp.
          if (accept) begin
            tgt_d  = req.target;
            rate_d = (req.rate == '0) ? R'(1) : req.rate;
            div_d  = '0;
            if (req.target != duty_q) state_d = RAMP;
            else                      done_d  = 1'b1;
          end
        end
        RAMP: begin
          if (boundary) begin
            if (div_q == rate_q - R'(1)) begin
              div_d  = '0;
              duty_d = duty_nxt;
              if (duty_nxt == tgt_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              div_d = div_q + R'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      div_q   <= '0;
      rate_q  <= R'(1);
      tgt_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      rate_q  <= rate_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
      ps_q    <= ps_d;
    end
  end

endmodule
